// File: rtl/arf_mem_sequencer_pkg.sv
// Shared codes for the ARF memory sequencer: ARF function/select codes, command ops and FSM states.
package arf_pkg;

    localparam logic [1:0] FUN_DEC  = 2'b00;
    localparam logic [1:0] FUN_INC  = 2'b01;
    localparam logic [1:0] FUN_LOAD = 2'b10;
    localparam logic [1:0] FUN_CLR  = 2'b11;

    localparam logic [1:0] OUT_AR  = 2'b00;
    localparam logic [1:0] OUT_SP  = 2'b01;
    localparam logic [1:0] OUT_PCP = 2'b10;
    localparam logic [1:0] OUT_PC  = 2'b11;

    // Bit positions inside arf_r_sel = {AR, SP, PC_past, PC}
    localparam int RSEL_PC  = 0;
    localparam int RSEL_PCP = 1;
    localparam int RSEL_SP  = 2;
    localparam int RSEL_AR  = 3;

    localparam logic [3:0] RSEL_NONE = 4'b0000;
    localparam logic [3:0] RSEL_ALL  = 4'b1111;

    typedef enum logic [2:0] {
        OP_FETCH  = 3'b000,
        OP_LOAD   = 3'b001,
        OP_STORE  = 3'b010,
        OP_PUSH   = 3'b011,
        OP_POP    = 3'b100,
        OP_CLRALL = 3'b101,
        OP_ILL6   = 3'b110,
        OP_ILL7   = 3'b111
    } cmd_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_MEM  = 3'd2,
        ST_POST = 3'd3,
        ST_CLR  = 3'd4,
        ST_RSP  = 3'd5
    } state_t;

    function automatic logic [1:0] mem_out_sel(input cmd_op_t op);
        case (op)
            OP_FETCH:        return OUT_PC;
            OP_PUSH, OP_POP: return OUT_SP;
            default:         return OUT_AR;
        endcase
    endfunction

    function automatic logic [3:0] rsel_mask(input int pos);
        return 4'(1) << pos;
    endfunction

endpackage

// File: rtl/arf_mem_sequencer_if.sv
// Bus bundle between the sequencer (slave) and its environment: command, response, ARF and memory.
interface arf_mem_sequencer_if;

    // Every channel transfers on a rising edge where valid (or mem_req) and ready (or mem_ack) are
    // both high; the initiator holds its payload stable until that edge.
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_wdata;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;

    logic [3:0] arf_r_sel;
    logic [1:0] arf_funsel;
    logic [1:0] arf_out_b_sel;
    logic [7:0] arf_out_b;

    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_ack;
    logic [7:0] mem_rdata;

    modport slave (
        input  cmd_valid, cmd_op, cmd_wdata, rsp_ready, arf_out_b, mem_ack, mem_rdata,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
        output arf_r_sel, arf_funsel, arf_out_b_sel,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cmd_valid, cmd_op, cmd_wdata, rsp_ready, arf_out_b, mem_ack, mem_rdata,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
        input  arf_r_sel, arf_funsel, arf_out_b_sel,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/arf_mem_sequencer.sv
// Command sequencer driving the address register file and one memory handshake per command.
// Optional MEM-state timeout is enabled by defining ARF_SEQ_TIMEOUT_EN.
module arf_mem_sequencer
    import arf_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                                    clk,
    input  logic                                    rst,
    arf_mem_sequencer_if.slave                      bus,
    output state_t                                  state_dbg,
    output logic [$clog2(TIMEOUT_CYCLES+1)-1:0]     dbg_tmo_cnt
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t            state;
    cmd_op_t           op_q;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              tmo_hit;

    assign state_dbg     = state;
    assign dbg_tmo_cnt   = tmo_cnt;
    assign bus.mem_addr  = bus.arf_out_b;

`ifdef ARF_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst || state != ST_MEM || bus.mem_ack) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
    assign tmo_hit = (state == ST_MEM) && !bus.mem_ack &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_cnt = '0;
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            op_q              <= OP_FETCH;
            bus.cmd_ready     <= 1'b1;
            bus.rsp_valid     <= 1'b0;
            bus.rsp_err       <= 1'b0;
            bus.rsp_data      <= '0;
            bus.mem_req       <= 1'b0;
            bus.mem_we        <= 1'b0;
            bus.mem_wdata     <= '0;
            bus.arf_r_sel     <= RSEL_NONE;
            bus.arf_funsel    <= FUN_DEC;
            bus.arf_out_b_sel <= OUT_AR;
        end else begin
            // ARF enables are one-cycle pulses; only PRE/POST/CLR entries raise them.
            bus.arf_r_sel <= RSEL_NONE;
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q          <= cmd_op_t'(bus.cmd_op);
                        bus.mem_wdata <= bus.cmd_wdata;
                        bus.rsp_data  <= '0;
                        bus.rsp_err   <= 1'b0;
                        bus.cmd_ready <= 1'b0;
                        case (cmd_op_t'(bus.cmd_op))
                            OP_PUSH: begin
                                state          <= ST_PRE;
                                bus.arf_r_sel  <= rsel_mask(RSEL_SP);
                                bus.arf_funsel <= FUN_DEC;
                            end
                            OP_FETCH, OP_LOAD, OP_STORE, OP_POP: begin
                                state             <= ST_MEM;
                                bus.mem_req       <= 1'b1;
                                bus.mem_we        <= (cmd_op_t'(bus.cmd_op) == OP_STORE);
                                bus.arf_out_b_sel <= mem_out_sel(cmd_op_t'(bus.cmd_op));
                            end
                            OP_CLRALL: begin
                                state          <= ST_CLR;
                                bus.arf_r_sel  <= RSEL_ALL;
                                bus.arf_funsel <= FUN_CLR;
                            end
                            default: begin
                                state         <= ST_RSP;
                                bus.rsp_valid <= 1'b1;
                                bus.rsp_err   <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_PRE: begin
                    state             <= ST_MEM;
                    bus.mem_req       <= 1'b1;
                    bus.mem_we        <= 1'b1;
                    bus.arf_out_b_sel <= OUT_SP;
                end
                ST_MEM: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        if (!bus.mem_we) begin
                            bus.rsp_data <= bus.mem_rdata;
                        end
                        if (op_q == OP_FETCH || op_q == OP_POP) begin
                            state          <= ST_POST;
                            bus.arf_r_sel  <= (op_q == OP_FETCH) ? rsel_mask(RSEL_PC)
                                                                 : rsel_mask(RSEL_SP);
                            bus.arf_funsel <= FUN_INC;
                        end else begin
                            state         <= ST_RSP;
                            bus.rsp_valid <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        // Abandon the access; any PUSH pre-decrement stays in place.
                        bus.mem_req   <= 1'b0;
                        bus.mem_we    <= 1'b0;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                        state         <= ST_RSP;
                    end
                end
                ST_POST, ST_CLR: begin
                    state         <= ST_RSP;
                    bus.rsp_valid <= 1'b1;
                end
                ST_RSP: begin
                    if (bus.rsp_ready) begin
                        state         <= ST_IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    bus.cmd_ready <= 1'b1;
                    bus.rsp_valid <= 1'b0;
                    bus.mem_req   <= 1'b0;
                    bus.mem_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arf_mem_sequencer.sv
// Bench for arf_mem_sequencer with a behavioural ARF, a 256x8 memory with configurable ack delay,
// and a command-level reference model.
module tb_arf_mem_sequencer;
    import arf_pkg::*;

    localparam int NEVER = 1000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arf_mem_sequencer_if bus();
    state_t     state_dbg;
    logic [3:0] dbg_tmo_cnt;

    arf_mem_sequencer #(.TIMEOUT_CYCLES(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .state_dbg   (state_dbg),
        .dbg_tmo_cnt (dbg_tmo_cnt)
    );

    // ---------------- behavioural ARF ----------------
    logic [7:0] pc  = 8'h10;
    logic [7:0] ar  = 8'h40;
    logic [7:0] sp  = 8'h80;
    logic [7:0] pcp = 8'h22;

    function automatic logic [7:0] arf_apply(input logic [7:0] v, input logic [1:0] f);
        case (f)
            2'b00:   return v - 8'd1;
            2'b01:   return v + 8'd1;
            2'b10:   return v;
            default: return 8'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.arf_r_sel[0]) pc  <= arf_apply(pc,  bus.arf_funsel);
        if (bus.arf_r_sel[1]) pcp <= arf_apply(pcp, bus.arf_funsel);
        if (bus.arf_r_sel[2]) sp  <= arf_apply(sp,  bus.arf_funsel);
        if (bus.arf_r_sel[3]) ar  <= arf_apply(ar,  bus.arf_funsel);
    end

    assign bus.arf_out_b = (bus.arf_out_b_sel == 2'b00) ? ar  :
                           (bus.arf_out_b_sel == 2'b01) ? sp  :
                           (bus.arf_out_b_sel == 2'b10) ? pcp : pc;

    // ---------------- behavioural memory with ack delay ----------------
    logic [7:0] mem [256];
    int         ack_delay = 0;
    int         wcnt = 0;

    function automatic logic [7:0] init_val(input int i);
        return 8'((i * 37) + 11);
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_val(i);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'hEE;
        forever begin
            @(posedge clk);
            if (bus.mem_req && bus.mem_ack && bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
            @(negedge clk);
            if (bus.mem_req) begin
                if (wcnt == ack_delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem[bus.mem_addr];
                end else begin
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = 8'hEE;
                end
                wcnt++;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 8'hEE;
                wcnt          = 0;
            end
        end
    end

    // ---------------- scoreboard / reference model ----------------
    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] ref_mem [256];
    logic [7:0] m_pc = 8'h10;
    logic [7:0] m_ar = 8'h40;
    logic [7:0] m_sp = 8'h80;
    logic [7:0] m_pcp = 8'h22;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_pc"},  32'(pc),  32'(m_pc));
        check({tag, "_ar"},  32'(ar),  32'(m_ar));
        check({tag, "_sp"},  32'(sp),  32'(m_sp));
        check({tag, "_pcp"}, 32'(pcp), 32'(m_pcp));
    endtask

    // Command-level outcome: response, latency counted from the accept edge inclusive,
    // number of cycles mem_req is high, and number of cycles any ARF enable is raised.
    task automatic do_cmd(input string tag, input logic [2:0] op, input logic [7:0] wd,
                          input int d, input int stall);
        logic [7:0] exp_data = 8'h00;
        logic       exp_err  = 1'b0;
        int         exp_lat, exp_mreq, exp_rsel;
        logic       wr = 1'b0;
        logic [7:0] waddr = 8'h00;
        bit         timed_out = 1'b0;
        int         edges, mreq_cnt, rsel_cnt, busy_ready;
`ifdef ARF_SEQ_TIMEOUT_EN
        timed_out = (d >= 15) && (op <= 3'd4);
`endif
        exp_mreq = timed_out ? 15 : d + 1;
        exp_rsel = 0;
        case (op)
            3'd0: begin
                if (!timed_out) begin exp_data = ref_mem[m_pc]; m_pc = m_pc + 8'd1; exp_rsel = 1; end
                exp_lat = timed_out ? 16 : 3 + d;
            end
            3'd1: begin
                if (!timed_out) exp_data = ref_mem[m_ar];
                exp_lat = timed_out ? 16 : 2 + d;
            end
            3'd2: begin
                if (!timed_out) begin ref_mem[m_ar] = wd; wr = 1'b1; waddr = m_ar; end
                exp_lat = timed_out ? 16 : 2 + d;
            end
            3'd3: begin
                m_sp = m_sp - 8'd1;
                exp_rsel = 1;
                if (!timed_out) begin ref_mem[m_sp] = wd; wr = 1'b1; waddr = m_sp; end
                exp_lat = timed_out ? 17 : 3 + d;
            end
            3'd4: begin
                if (!timed_out) begin exp_data = ref_mem[m_sp]; m_sp = m_sp + 8'd1; exp_rsel = 1; end
                exp_lat = timed_out ? 16 : 3 + d;
            end
            3'd5: begin
                m_pc = 8'h00; m_ar = 8'h00; m_sp = 8'h00; m_pcp = 8'h00;
                exp_lat = 2; exp_mreq = 0; exp_rsel = 1;
            end
            default: begin
                exp_err = 1'b1; exp_lat = 1; exp_mreq = 0;
            end
        endcase
        if (timed_out) exp_err = 1'b1;
        exp_q.push_back(exp_data);

        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_wdata = wd;
        ack_delay     = d;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        bus.cmd_wdata = $urandom_range(0, 255);
        edges = 1; mreq_cnt = 0; rsel_cnt = 0; busy_ready = 0;
        @(negedge clk);
        while (!bus.rsp_valid && edges < 100) begin
            if (bus.mem_req) mreq_cnt++;
            if (bus.arf_r_sel != 4'b0000) rsel_cnt++;
            if (bus.cmd_ready) busy_ready++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({tag, "_latency"},   32'(edges), 32'(exp_lat));
        check({tag, "_rsp_err"},   32'(bus.rsp_err), 32'(exp_err));
        check({tag, "_rsp_data"},  32'(bus.rsp_data), 32'(exp_q.pop_front()));
        check({tag, "_mreq_cyc"},  32'(mreq_cnt), 32'(exp_mreq));
        check({tag, "_rsel_cyc"},  32'(rsel_cnt), 32'(exp_rsel));
        check({tag, "_busy_rdy"},  32'(busy_ready), 32'd0);
        check({tag, "_rsp_rsel"},  32'(bus.arf_r_sel), 32'd0);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_stall_valid"}, 32'(bus.rsp_valid), 32'd1);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({tag, "_rsp_drop"},  32'(bus.rsp_valid), 32'd0);
        check({tag, "_idle_rdy"},  32'(bus.cmd_ready), 32'd1);
        check_regs(tag);
        if (wr) check({tag, "_memwr"}, 32'(mem[waddr]), 32'(ref_mem[waddr]));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_wdata = 8'h00;
        bus.rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
        check("rst_mem_req",   32'(bus.mem_req), 32'd0);
        check("rst_mem_we",    32'(bus.mem_we), 32'd0);
        check("rst_r_sel",     32'(bus.arf_r_sel), 32'd0);
        check("rst_funsel",    32'(bus.arf_funsel), 32'd0);
        check("rst_out_b_sel", 32'(bus.arf_out_b_sel), 32'd0);
        check("rst_rsp_data",  32'(bus.rsp_data), 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_state",     32'(state_dbg), 32'(ST_IDLE));
        rst = 1'b0;

        // Random commands from the non-cleared register start point
        for (int n = 0; n < 40; n++) begin
            do_cmd("rand", 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                   $urandom_range(0, 3), $urandom_range(0, 2));
        end

        // Directed scenarios
        do_cmd("clrall",   3'd5, 8'h00, 0, 0);
        do_cmd("store_a5", 3'd2, 8'hA5, 0, 0);
        do_cmd("fetch_a5", 3'd0, 8'h00, 0, 0);
        do_cmd("clrall2",  3'd5, 8'h00, 0, 0);
        do_cmd("push_3c",  3'd3, 8'h3C, 0, 0);
        check("push_ff_mem", 32'(mem[8'hFF]), 32'h3C);
        check("push_sp_ff",  32'(sp), 32'hFF);
        do_cmd("pop_3c",   3'd4, 8'h00, 0, 0);
        check("pop_sp_00",   32'(sp), 32'h00);
        do_cmd("store_77", 3'd2, 8'h77, 0, 0);
        do_cmd("load_77",  3'd1, 8'h00, 4, 3);
        do_cmd("ill_110",  3'd6, 8'h00, 0, 0);
        do_cmd("ill_111",  3'd7, 8'h00, 0, 1);

        // PC wrap: walk PC to FF by fetches is long, so fetch repeatedly from a cleared file
        for (int n = 0; n < 3; n++) do_cmd("fetch_seq", 3'd0, 8'h00, n, 0);

        // Reset during the MEM phase of a PUSH
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd3;
        bus.cmd_wdata = 8'h5A;
        ack_delay     = NEVER;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        m_sp = m_sp - 8'd1;
        check("mid_push_req", 32'(bus.mem_req), 32'd1);
        check("mid_cmd_busy", 32'(bus.cmd_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_state",   32'(state_dbg), 32'(ST_IDLE));
        check("rstmid_mem_req", 32'(bus.mem_req), 32'd0);
        check("rstmid_ready",   32'(bus.cmd_ready), 32'd1);
        check("rstmid_rsp",     32'(bus.rsp_valid), 32'd0);
        check_regs("rstmid");
        ack_delay = 0;
        do_cmd("post_rst_pop", 3'd4, 8'h00, 1, 0);

`ifdef ARF_SEQ_TIMEOUT_EN
        do_cmd("tmo_fetch", 3'd0, 8'h00, NEVER, 0);
        do_cmd("tmo_push",  3'd3, 8'h99, NEVER, 1);
        do_cmd("after_tmo", 3'd1, 8'h00, 2, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
